time_set_ctrl: RTL and testbench

Button-driven controller that sequences the time/date calculator through its setting modes. It snapshots the running time, date and alarm and lets the user edit one field at a time with wrap-around arithmetic. On confirmation it commits the edited values with a SETTING or ALARM_SETTING request held until SETTING_OK. It sits between the debounced keypad and the time calculator and drives all of that block's mode and setting inputs.

---
 rtl/time_set_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_time_set_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// Keypad-driven time/date/alarm setting controller for the time calculator.
// Define MONTH_DAYS_EN for calendar-accurate day limits and day clamping; otherwise every month allows 31 days.
module time_set_ctrl #(
    parameter int unsigned EDIT_TIMEOUT = 1000000,
    parameter int unsigned OK_TIMEOUT   = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        BTN_MODE,
    input  logic        BTN_NEXT,
    input  logic        BTN_UP,
    input  logic        BTN_DOWN,
    input  logic [16:0] CUR_TIME,
    input  logic [15:0] CUR_DATE,
    input  logic [16:0] CUR_ALARM,
    input  logic        SETTING_OK,
    output logic        MODE,
    output logic        MODE_STATE,
    output logic        SETTING,
    output logic        ALARM_SETTING,
    output logic [16:0] SET_TIME,
    output logic [15:0] SET_DATE,
    output logic [16:0] SET_ALARM,
    output logic [2:0]  FIELD,
    output logic        ERR,
    output logic [2:0]  DBG_STATE
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_ALARM_VIEW = 3'd1, S_EDIT_CLK = 3'd2,
        S_COMMIT_CLK = 3'd3, S_EDIT_ALM = 3'd4, S_COMMIT_ALM = 3'd5
    } state_t;

    localparam int EW = $clog2(EDIT_TIMEOUT + 1);
    localparam int OW = $clog2(OK_TIMEOUT + 1);

    state_t        state_q, state_d;
    logic [3:0]    btn_lvl_q, btn_prev_q;
    logic [16:0]   time_q, time_d, alarm_q, alarm_d;
    logic [15:0]   date_q, date_d, date_adj;
    logic [2:0]    field_q, field_d;
    logic          err_q, err_d;
    logic          mode_q, mode_state_q, setting_q, alarm_setting_q;
    logic [EW-1:0] edit_cnt_q, edit_cnt_d;
    logic [OW-1:0] ok_cnt_q, ok_cnt_d;
    logic [3:0]    edges;
    logic          any_edge, act_mode, act_next, act_up, act_adj;
    logic [6:0]    yr;
    logic [3:0]    mo;
    logic [4:0]    dy, dmax_cur;

    // Wrap-around step; an out-of-range value lands on the bound it is moving toward.
    function automatic logic [6:0] step(input logic [6:0] v, input logic [6:0] lo,
                                        input logic [6:0] hi, input logic up);
        if (up) return (v < lo || v >= hi) ? lo : v + 7'd1;
        else    return (v <= lo || v > hi) ? hi : v - 7'd1;
    endfunction

    function automatic logic [16:0] adj_time(input logic [16:0] t, input logic [2:0] f,
                                             input logic up);
        logic [16:0] r;
        r = t;
        case (f)
            3'd0: r[16:12] = 5'(step({2'b00, t[16:12]}, 7'd0, 7'd23, up));
            3'd1: r[11:6]  = 6'(step({1'b0, t[11:6]}, 7'd0, 7'd59, up));
            3'd2: r[5:0]   = 6'(step({1'b0, t[5:0]}, 7'd0, 7'd59, up));
            default: ;
        endcase
        return r;
    endfunction

`ifdef MONTH_DAYS_EN
    function automatic logic [4:0] dmax_f(input logic [3:0] m, input logic [1:0] y_lo);
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
            4'd2:                    return (y_lo == 2'b00) ? 5'd29 : 5'd28;
            default:                 return 5'd31;
        endcase
    endfunction
`endif

    // Edge order {MODE, NEXT, UP, DOWN}; only the highest-priority edge acts.
    assign edges    = btn_lvl_q & ~btn_prev_q;
    assign any_edge = |edges;
    assign act_mode = edges[3];
    assign act_next = edges[2] & ~edges[3];
    assign act_up   = edges[1] & ~edges[2] & ~edges[3];
    assign act_adj  = (edges[1] | edges[0]) & ~edges[2] & ~edges[3];

    always_comb begin
        yr = date_q[15:9];
        mo = date_q[8:5];
        dy = date_q[4:0];
`ifdef MONTH_DAYS_EN
        dmax_cur = dmax_f(date_q[8:5], date_q[10:9]);
`else
        dmax_cur = 5'd31;
`endif
        case (field_q)
            3'd3: yr = step(yr, 7'd0, 7'd99, act_up);
            3'd4: mo = 4'(step({3'b000, mo}, 7'd1, 7'd12, act_up));
            3'd5: dy = 5'(step({2'b00, dy}, 7'd1, {2'b00, dmax_cur}, act_up));
            default: ;
        endcase
`ifdef MONTH_DAYS_EN
        if ((field_q == 3'd3 || field_q == 3'd4) && dy > dmax_f(mo, yr[1:0]))
            dy = dmax_f(mo, yr[1:0]);
`endif
        date_adj = {yr, mo, dy};
    end

    always_comb begin
        state_d    = state_q;
        time_d     = time_q;
        date_d     = date_q;
        alarm_d    = alarm_q;
        field_d    = field_q;
        err_d      = err_q;
        edit_cnt_d = edit_cnt_q;
        ok_cnt_d   = ok_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (act_mode) begin
                    state_d = S_EDIT_CLK;  time_d = CUR_TIME;  date_d = CUR_DATE;
                    field_d = 3'd0;  err_d = 1'b0;  edit_cnt_d = '0;
                end else if (act_next) state_d = S_ALARM_VIEW;
            end
            S_ALARM_VIEW: begin
                if (act_mode) begin
                    state_d = S_EDIT_ALM;  alarm_d = CUR_ALARM;
                    field_d = 3'd0;  err_d = 1'b0;  edit_cnt_d = '0;
                end else if (act_next) state_d = S_IDLE;
            end
            S_EDIT_CLK, S_EDIT_ALM: begin
                if (any_edge) edit_cnt_d = '0;
                if (act_mode) begin
                    state_d  = (state_q == S_EDIT_CLK) ? S_COMMIT_CLK : S_COMMIT_ALM;
                    ok_cnt_d = '0;
                end else if (act_next) begin
                    if (state_q == S_EDIT_CLK) field_d = (field_q >= 3'd5) ? 3'd0 : field_q + 3'd1;
                    else                       field_d = (field_q >= 3'd2) ? 3'd0 : field_q + 3'd1;
                end else if (act_adj) begin
                    if (state_q == S_EDIT_CLK) begin
                        time_d = adj_time(time_q, field_q, act_up);
                        date_d = date_adj;
                    end else alarm_d = adj_time(alarm_q, field_q, act_up);
                end else if (edit_cnt_q == EW'(EDIT_TIMEOUT - 1)) begin
                    state_d = (state_q == S_EDIT_CLK) ? S_IDLE : S_ALARM_VIEW;
                end else edit_cnt_d = edit_cnt_q + EW'(1);
            end
            // Request is held while in commit; the cycle after SETTING_OK is sampled high it drops.
            S_COMMIT_CLK, S_COMMIT_ALM: begin
                if (SETTING_OK) begin
                    state_d = (state_q == S_COMMIT_CLK) ? S_IDLE : S_ALARM_VIEW;
                end else if (ok_cnt_q == OW'(OK_TIMEOUT - 1)) begin
                    state_d = (state_q == S_COMMIT_CLK) ? S_IDLE : S_ALARM_VIEW;
                    err_d   = 1'b1;
                end else ok_cnt_d = ok_cnt_q + OW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q         <= S_IDLE;
            btn_lvl_q       <= 4'd0;
            btn_prev_q      <= 4'd0;
            time_q          <= 17'd0;
            date_q          <= {7'd16, 4'd1, 5'd1};
            alarm_q         <= 17'd0;
            field_q         <= 3'd0;
            err_q           <= 1'b0;
            edit_cnt_q      <= '0;
            ok_cnt_q        <= '0;
            mode_q          <= 1'b0;
            mode_state_q    <= 1'b0;
            setting_q       <= 1'b0;
            alarm_setting_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            btn_lvl_q       <= {BTN_MODE, BTN_NEXT, BTN_UP, BTN_DOWN};
            btn_prev_q      <= btn_lvl_q;
            time_q          <= time_d;
            date_q          <= date_d;
            alarm_q         <= alarm_d;
            field_q         <= field_d;
            err_q           <= err_d;
            edit_cnt_q      <= edit_cnt_d;
            ok_cnt_q        <= ok_cnt_d;
            mode_q          <= (state_d == S_EDIT_CLK) || (state_d == S_COMMIT_CLK);
            mode_state_q    <= (state_d == S_ALARM_VIEW) || (state_d == S_EDIT_ALM) ||
                               (state_d == S_COMMIT_ALM);
            setting_q       <= (state_d == S_COMMIT_CLK);
            alarm_setting_q <= (state_d == S_COMMIT_ALM);
        end
    end

    assign MODE          = mode_q;
    assign MODE_STATE    = mode_state_q;
    assign SETTING       = setting_q;
    assign ALARM_SETTING = alarm_setting_q;
    assign SET_TIME      = time_q;
    assign SET_DATE      = date_q;
    assign SET_ALARM     = alarm_q;
    assign FIELD         = field_q;
    assign ERR           = err_q;
    assign DBG_STATE     = state_q;
endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: edit, wrap, clamp, commit handshake, timeouts, reset.
// Expected day values follow MONTH_DAYS_EN when the same macro is defined for the bench.
module tb_time_set_ctrl;
    localparam int TB_EDIT_TO = 40;
    localparam logic [2:0] ST_IDLE = 3'd0, ST_AVIEW = 3'd1, ST_ECLK = 3'd2,
                           ST_CCLK = 3'd3, ST_EALM = 3'd4, ST_CALM = 3'd5;

    logic        clk = 1'b0, rst = 1'b1;
    logic        b_mode = 0, b_next = 0, b_up = 0, b_down = 0, ok = 0;
    logic [16:0] cur_time = '0, cur_alarm = '0;
    logic [15:0] cur_date = '0;
    logic        mode, mode_state, setting, alarm_setting, err;
    logic [16:0] set_time, set_alarm;
    logic [15:0] set_date;
    logic [2:0]  field, dbg_state;
    int          checks = 0, errors = 0, n;

    time_set_ctrl #(.EDIT_TIMEOUT(TB_EDIT_TO), .OK_TIMEOUT(8)) dut (
        .CLK(clk), .RESET(rst), .BTN_MODE(b_mode), .BTN_NEXT(b_next), .BTN_UP(b_up),
        .BTN_DOWN(b_down), .CUR_TIME(cur_time), .CUR_DATE(cur_date), .CUR_ALARM(cur_alarm),
        .SETTING_OK(ok), .MODE(mode), .MODE_STATE(mode_state), .SETTING(setting),
        .ALARM_SETTING(alarm_setting), .SET_TIME(set_time), .SET_DATE(set_date),
        .SET_ALARM(set_alarm), .FIELD(field), .ERR(err), .DBG_STATE(dbg_state));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] mk_time(input int h, input int m, input int s);
        return {5'(h), 6'(m), 6'(s)};
    endfunction

    function automatic logic [15:0] mk_date(input int y, input int mo, input int d);
        return {7'(y), 4'(mo), 5'(d)};
    endfunction

    // Mask {MODE, NEXT, UP, DOWN}; returns at the negedge after the edge has acted.
    task automatic press(input logic [3:0] m);
        @(negedge clk);
        {b_mode, b_next, b_up, b_down} = m;
        @(negedge clk);
        {b_mode, b_next, b_up, b_down} = 4'b0000;
        @(negedge clk);
    endtask

    task automatic measure(input int ok_at, input bit alm, output int cnt);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if ((alm ? alarm_setting : setting) !== 1'b1) break;
            cnt++;
            if (cnt == ok_at) ok = 1'b1;
            @(negedge clk);
        end
        ok = 1'b0;
    endtask

    task automatic wait_timeout(input string tag, input logic [2:0] edit_s, input logic [2:0] exit_s);
        repeat (TB_EDIT_TO - 1) @(negedge clk);
        check({tag, "_still_edit"}, dbg_state, edit_s);
        @(negedge clk);
        check({tag, "_exit"}, dbg_state, exit_s);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_mode", mode, 0);
        check("rst_mode_state", mode_state, 0);
        check("rst_setting", setting, 0);
        check("rst_alarm_setting", alarm_setting, 0);
        check("rst_err", err, 0);
        check("rst_set_time", set_time, 0);
        check("rst_set_alarm", set_alarm, 0);
        check("rst_set_date", set_date, 16'h2021);
        check("rst_field", field, 0);
        check("rst_state", dbg_state, ST_IDLE);

        cur_time = mk_time(23, 59, 58);
        cur_date = mk_date(16, 1, 31);
        press(4'b1000);
        check("edit_mode", mode, 1);
        check("snap_time", set_time, mk_time(23, 59, 58));
        check("snap_date", set_date, mk_date(16, 1, 31));
        check("edit_state", dbg_state, ST_ECLK);
        press(4'b0010);
        check("hour_wrap_up", set_time, mk_time(0, 59, 58));
        press(4'b0100);
        check("field1", field, 1);
        press(4'b0010);
        check("min_wrap_up", set_time, mk_time(0, 0, 58));
        press(4'b0001);
        check("min_wrap_down", set_time, mk_time(0, 59, 58));
        press(4'b0100);
        press(4'b0010);
        check("sec_up", set_time, mk_time(0, 59, 59));
        press(4'b0100);
        press(4'b0100);
        check("field4", field, 4);
        press(4'b0010);
`ifdef MONTH_DAYS_EN
        check("month_up_clamp", set_date, mk_date(16, 2, 29));
`else
        check("month_up_noclamp", set_date, mk_date(16, 2, 31));
`endif
        press(4'b0100);
        press(4'b0010);
        check("day_wrap_up", set_date, mk_date(16, 2, 1));
        press(4'b0001);
`ifdef MONTH_DAYS_EN
        check("day_wrap_down", set_date, mk_date(16, 2, 29));
`else
        check("day_wrap_down", set_date, mk_date(16, 2, 31));
`endif
        press(4'b0100);
        check("field_wrap", field, 0);
        press(4'b0110);
        check("prio_next_field", field, 1);
        check("prio_next_time", set_time, mk_time(0, 59, 59));
        press(4'b0100);
        press(4'b0100);
        press(4'b0010);
`ifdef MONTH_DAYS_EN
        check("year_up_clamp", set_date, mk_date(17, 2, 28));
`else
        check("year_up_noclamp", set_date, mk_date(17, 2, 31));
`endif

        press(4'b1000);
        check("commit_state", dbg_state, ST_CCLK);
        measure(2, 1'b0, n);
        check("ok_pulse_len", n, 2);
        check("ok_state", dbg_state, ST_IDLE);
        check("ok_mode", mode, 0);
        check("ok_err", err, 0);
        check("ok_time_held", set_time, mk_time(0, 59, 59));

        press(4'b1000);
        press(4'b1000);
        measure(0, 1'b0, n);
        check("to_pulse_len", n, 8);
        check("to_err", err, 1);
        check("to_state", dbg_state, ST_IDLE);

        cur_time = mk_time(12, 34, 56);
        press(4'b1000);
        check("err_cleared", err, 0);
        press(4'b1010);
        check("mode_up_state", dbg_state, ST_CCLK);
        check("mode_up_setting", setting, 1);
        check("mode_up_time", set_time, mk_time(12, 34, 56));
        #2 rst = 1'b1;
        #1;
        check("rst_commit_setting", setting, 0);
        check("rst_commit_mode", mode, 0);
        check("rst_commit_state", dbg_state, ST_IDLE);
        check("rst_commit_time", set_time, 0);
        @(negedge clk);
        rst = 1'b0;

        cur_alarm = mk_time(6, 29, 1);
        press(4'b0100);
        check("aview_state", dbg_state, ST_AVIEW);
        check("aview_mode_state", mode_state, 1);
        press(4'b1000);
        check("ealm_state", dbg_state, ST_EALM);
        check("ealm_snap", set_alarm, mk_time(6, 29, 1));
        check("ealm_mode", mode, 0);
        press(4'b0010);
        press(4'b0100);
        press(4'b0010);
        press(4'b0100);
        press(4'b0001);
        check("alarm_edit", set_alarm, mk_time(7, 30, 0));
        press(4'b0100);
        check("alarm_field_wrap", field, 0);
        press(4'b1000);
        check("calm_setting", setting, 0);
        measure(1, 1'b1, n);
        check("alarm_pulse_len", n, 1);
        check("alarm_ret_state", dbg_state, ST_AVIEW);
        check("alarm_value", set_alarm, {5'd7, 6'd30, 6'd0});
        check("alarm_err", err, 0);

        press(4'b1000);
        wait_timeout("alm_to", ST_EALM, ST_AVIEW);
        check("alm_to_no_req", alarm_setting, 0);
        press(4'b0100);
        check("back_idle", dbg_state, ST_IDLE);
        press(4'b1000);
        repeat (30) @(negedge clk);
        press(4'b0010);
        wait_timeout("clk_to", ST_ECLK, ST_IDLE);
        check("clk_to_no_req", setting, 0);
        check("clk_to_mode", mode, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
